led_matrix_scanner: RTL and testbench
=====================================

# led_matrix_scanner

Column-scan controller for the 4-column × 7-row irrigation status LED matrix. It double-buffers a frame written by the display logic and steps through the four columns with a blanking gap between them to prevent ghosting. It produces the 2-bit column select and the row-major row data consumed directly downstream by the bank of seven `driver_mux_4x1` instances, one per row. It also drives the active-low column enables.

## Interface
- `DRIVE_CYCLES`, default 12500: clock cycles each column is lit (250 µs at 50 MHz, ≈1 kHz frame rate); must be ≥ 1.
- `BLANK_CYCLES`, default 50: clock cycles with all columns off before each column is lit; must be ≥ 1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: scanning on when high; off (all columns dark) when low.
- `frame_in` input 28: new frame, column-major; column c, row r is at bit 7c+r.
- `frame_load` input 1: single-cycle strobe that captures `frame_in`.
- `frame_pending` output 1: a loaded frame is waiting for the next frame boundary.
- `frame_sync` output 1: one-cycle pulse when a frame is committed at a scan wrap.
- `row_bus` output 28: displayed frame, row-major; row r, column c is at bit 4r+c. Bits [4r+3:4r] feed `rows_values` of the row-r mux.
- `col_sel` output 2: current column index; feeds `bin_number_sel` of all row muxes.
- `col_en_n` output 4: active-low column enables, at most one bit low.

## Operation
- **Registers:**
  - `pend`: 28-bit pending buffer.
  - `shadow`: 28-bit displayed frame.
  - Cycle counter sized for max(`DRIVE_CYCLES`, `BLANK_CYCLES`).
  - 2-bit column counter.
  - FSM with states OFF, BLANK, DRIVE.
- **Reset** (wins over every other input): FSM=OFF, counter=0, `col_sel`=0, `col_en_n`=4'b1111, `pend`=0, `shadow`=0, `row_bus`=0, `frame_pending`=0, `frame_sync`=0.
- **Load:** `frame_load`=1 stores `frame_in` into `pend` and sets `frame_pending`=1 next cycle. A load while already pending overwrites `pend`; the last load wins.
- **Commit** (`shadow` <= `pend`, `frame_pending` <= 0) happens at:
  - the frame boundary, i.e. the last DRIVE cycle of column 3, or
  - any cycle in OFF while `frame_pending`=1.
- **Load coinciding with commit:** `frame_in` is committed directly, and `frame_pending` stays or becomes 0.
- **`row_bus`** is the row-major reordering of `shadow`, driven combinationally from `shadow`. It changes only on a commit.
- **OFF:** `col_en_n`=1111 and `col_sel`=0. On `enable`=1, go to BLANK with counter=0.
- **BLANK:** `col_en_n`=1111; `col_sel` already shows the upcoming column. After `BLANK_CYCLES` cycles, go to DRIVE with counter=0.
- **DRIVE:** `col_en_n[col_sel]`=0 and all other bits are 1. After `DRIVE_CYCLES` cycles, go to BLANK and advance `col_sel` (3 wraps to 0).
  - Wrapping from column 3 performs a commit only if `frame_pending`=1 or a load coincides.
  - `frame_sync`=1 for one cycle on every 3→0 wrap, whether or not the frame changed.
- **`enable`=0 in BLANK or DRIVE:** next cycle FSM=OFF, `col_en_n`=1111, `col_sel`=0, counter=0. `shadow` and `pend` are kept.
- **Outputs** `col_en_n`, `col_sel` and `frame_sync` are registered.

## Timing
- `enable` sampled high at edge k (FSM in OFF) → BLANK from k+1.
  - `col_en_n`=1110 from edge k+1+`BLANK_CYCLES`, lasting `DRIVE_CYCLES` cycles.
- Column period is `BLANK_CYCLES`+`DRIVE_CYCLES`; frame period is 4× that.
- `col_sel` changes only on the DRIVE→BLANK edge, so it is stable for the whole blanking gap before the column's enable falls.
- Load → visible latency:
  - In OFF: 1 cycle.
  - Otherwise: at most one frame period, applied on the same edge that sets `col_sel`=0 and pulses `frame_sync`.
- `row_bus` never changes while any `col_en_n` bit is low (no tearing).

## Test plan
Use `DRIVE_CYCLES`=4 and `BLANK_CYCLES`=2 unless noted.

- **Reset during DRIVE of column 2:** assert `reset` → next cycle `col_en_n`=1111, `col_sel`=0, `row_bus`=0, `frame_pending`=0, `frame_sync`=0.
- **Load then enable:**
  - Stimulus: with `enable`=0, load `frame_in`=28'h0000001 (column 0, row 0).
  - Expected: one cycle later `row_bus`=28'h0000001 and `frame_pending`=0.
  - Then raise `enable`: `col_en_n` sequence is 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, with `col_sel` stepping 0,1,2,3.
- **Mid-scan load:**
  - Stimulus: load 28'hFFFFFFF during column 1.
  - Expected: `frame_pending`=1 and `row_bus` unchanged through column 3. On the wrap edge, `row_bus`=28'hFFFFFFF, `frame_pending`=0, `frame_sync`=1 for exactly 1 cycle.
- **Double load:** loads of A then B within one frame → B is displayed after the wrap; A never appears.
- **Load on the commit edge:** `frame_load` on the last DRIVE cycle of column 3 → the new value appears at the wrap and `frame_pending` stays 0.
- **`enable` drop in DRIVE of column 1:** next cycle `col_en_n`=1111 and `col_sel`=0. Re-enabling restarts at BLANK of column 0 with `row_bus` preserved.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//
// Column-scan controller for the 4-column x 7-row status LED matrix.
// A frame written by the display logic is held in a pending buffer. It is
// moved into the displayed (shadow) frame only at a frame boundary, or
// straight away while the scanner is off. This means the displayed rows
// never change while a column is lit. Each column is lit for DRIVE_CYCLES.
// Before each column there are BLANK_CYCLES with every column dark.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   enable        scanning on when high, all columns dark when low
//   frame_in      new frame, column-major (column c, row r at bit 7c+r)
//   frame_load    one-cycle strobe that captures frame_in
//   frame_pending a loaded frame is waiting for the next frame boundary
//   frame_sync    one-cycle pulse on every column 3 -> 0 wrap
//   row_bus       displayed frame, row-major (row r, column c at bit 4r+c)
//   col_sel       current column index
//   col_en_n      active-low column enables, at most one bit low
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_OFF   | scanning stopped, all columns dark, pending frame applied now
// ST_BLANK | all columns dark, col_sel already shows the upcoming column
// ST_DRIVE | column col_sel lit for DRIVE_CYCLES

module led_matrix_scanner #(
  parameter int DRIVE_CYCLES = 12500,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [27:0] frame_in,
  input  logic        frame_load,
  output logic        frame_pending,
  output logic        frame_sync,
  output logic [27:0] row_bus,
  output logic [1:0]  col_sel,
  output logic [3:0]  col_en_n
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  localparam int CNT_MAX = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [27:0]      pend;
  logic [27:0]      shadow;
  logic             wrap;
  logic             commit;

  // Last DRIVE cycle of column 3 with scanning still enabled. If enable drops
  // on this cycle, the scanner goes to OFF instead, and the OFF state applies
  // the pending frame.
  assign wrap = (state == ST_DRIVE) && enable && (col_sel == 2'd3) && (cnt == DRIVE_LAST);

  // A load that arrives on a commit edge bypasses pend. In OFF, a fresh load
  // first raises frame_pending and is applied on the following cycle.
  assign commit = (wrap && (frame_pending || frame_load)) ||
                  ((state == ST_OFF) && frame_pending);

  always_comb begin
    row_bus = '0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 4; c++) begin
        row_bus[4*r + c] = shadow[7*c + r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_OFF;
      cnt           <= '0;
      col_sel       <= 2'd0;
      col_en_n      <= 4'b1111;
      pend          <= '0;
      shadow        <= '0;
      frame_pending <= 1'b0;
      frame_sync    <= 1'b0;
    end else begin
      frame_sync <= wrap;

      // pend always tracks the latest load, so after any commit it equals shadow.
      if (frame_load) begin
        pend <= frame_in;
      end

      if (commit) begin
        shadow        <= frame_load ? frame_in : pend;
        frame_pending <= 1'b0;
      end else if (frame_load) begin
        frame_pending <= 1'b1;
      end

      case (state)
        ST_OFF: begin
          col_en_n <= 4'b1111;
          col_sel  <= 2'd0;
          cnt      <= '0;
          if (enable) begin
            state <= ST_BLANK;
          end
        end

        ST_BLANK: begin
          if (!enable) begin
            state    <= ST_OFF;
            col_en_n <= 4'b1111;
            col_sel  <= 2'd0;
            cnt      <= '0;
          end else if (cnt == BLANK_LAST) begin
            state    <= ST_DRIVE;
            cnt      <= '0;
            col_en_n <= ~(4'b0001 << col_sel);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DRIVE: begin
          if (!enable) begin
            state    <= ST_OFF;
            col_en_n <= 4'b1111;
            col_sel  <= 2'd0;
            cnt      <= '0;
          end else if (cnt == DRIVE_LAST) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            col_en_n <= 4'b1111;
            col_sel  <= col_sel + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state    <= ST_OFF;
          col_en_n <= 4'b1111;
          col_sel  <= 2'd0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

  localparam int DRIVE  = 4;
  localparam int BLANK  = 2;
  localparam int COL_P  = BLANK + DRIVE;
  localparam int FRAME_P = 4 * COL_P;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [27:0] frame_in;
  logic        frame_load;
  logic        frame_pending;
  logic        frame_sync;
  logic [27:0] row_bus;
  logic [1:0]  col_sel;
  logic [3:0]  col_en_n;

  int tests;
  int fails;

  // Reference model: the scan is described by a position m_t within the frame
  // period (0 .. FRAME_P-1) while scanning is on.
  bit          m_on;
  int          m_t;
  logic [27:0] m_pend;
  logic [27:0] m_shadow;
  bit          m_pending;
  bit          m_sync;

  led_matrix_scanner #(
    .DRIVE_CYCLES(DRIVE),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .frame_in     (frame_in),
    .frame_load   (frame_load),
    .frame_pending(frame_pending),
    .frame_sync   (frame_sync),
    .row_bus      (row_bus),
    .col_sel      (col_sel),
    .col_en_n     (col_en_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] to_rows(input logic [27:0] f);
    logic [27:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 7; r++)
        o[4*r + c] = f[7*c + r];
    return o;
  endfunction

  function automatic logic [3:0] exp_en();
    logic [3:0] e;
    e = 4'hF;
    if (m_on && ((m_t % COL_P) >= BLANK)) e[m_t / COL_P] = 1'b0;
    return e;
  endfunction

  function automatic logic [1:0] exp_sel();
    return m_on ? 2'(m_t / COL_P) : 2'd0;
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_on = 0; m_t = 0; m_pend = '0; m_shadow = '0; m_pending = 0; m_sync = 0;
    end else if (!m_on) begin
      m_sync = 0;
      if (m_pending) begin
        m_shadow  = frame_load ? frame_in : m_pend;
        m_pending = 0;
      end else if (frame_load) begin
        m_pending = 1;
      end
      if (frame_load) m_pend = frame_in;
      m_on = enable;
      m_t  = 0;
    end else if (!enable) begin
      m_sync = 0;
      if (frame_load) begin m_pend = frame_in; m_pending = 1; end
      m_on = 0;
      m_t  = 0;
    end else if (m_t == FRAME_P - 1) begin
      m_sync = 1;
      if (frame_load) begin
        m_pend = frame_in; m_shadow = frame_in; m_pending = 0;
      end else if (m_pending) begin
        m_shadow = m_pend; m_pending = 0;
      end
      m_t = 0;
    end else begin
      m_sync = 0;
      if (frame_load) begin m_pend = frame_in; m_pending = 1; end
      m_t++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("col_en_n", 28'(col_en_n), 28'(exp_en()));
    check("col_sel", 28'(col_sel), 28'(exp_sel()));
    check("row_bus", row_bus, to_rows(m_shadow));
    check("frame_pending", 28'(frame_pending), 28'(m_pending));
    check("frame_sync", 28'(frame_sync), 28'(m_sync));
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (!(m_on && m_t == target) && n < 200) begin
      tick();
      n++;
    end
    tests++;
    assert (n < 200) else begin
      fails++;
      $error("FAIL run_to_timeout observed=%0d expected=%0d", m_t, target);
    end
  endtask

  task automatic load_tick(input logic [27:0] v);
    frame_in   = v;
    frame_load = 1'b1;
    tick();
    frame_load = 1'b0;
  endtask

  initial begin
    logic [27:0] a, b, c;
    tests = 0; fails = 0;
    m_on = 0; m_t = 0; m_pend = '0; m_shadow = '0; m_pending = 0; m_sync = 0;
    reset = 1'b1; enable = 1'b0; frame_in = '0; frame_load = 1'b0;

    tick(); tick();
    check("reset_col_en_n", 28'(col_en_n), 28'hF);
    check("reset_row_bus", row_bus, 28'h0);
    reset = 1'b0;
    tick();

    // Load while off: visible one cycle after the load edge.
    load_tick(28'h0000001);
    check("off_load_pending", 28'(frame_pending), 28'h1);
    tick();
    check("off_load_row_bus", row_bus, 28'h0000001);
    check("off_load_pending_clr", 28'(frame_pending), 28'h0);

    // Enable and walk a full frame.
    enable = 1'b1;
    tick();
    check("first_blank_en", 28'(col_en_n), 28'hF);
    tick(); tick();
    check("first_drive_en", 28'(col_en_n), 28'hE);
    for (int i = 0; i < FRAME_P - 3; i++) tick();
    check("col3_drive_en", 28'(col_en_n), 28'h7);
    check("col3_sel", 28'(col_sel), 28'h3);
    tick();
    check("wrap_sync", 28'(frame_sync), 28'h1);

    // Mid-scan load during column 1.
    run_to(9);
    load_tick(28'hFFFFFFF);
    run_to(FRAME_P - 1);
    check("midscan_pending_held", 28'(frame_pending), 28'h1);
    check("midscan_row_bus_held", row_bus, 28'h0000001);
    tick();
    check("midscan_row_bus_new", row_bus, 28'hFFFFFFF);
    check("midscan_pending_clr", 28'(frame_pending), 28'h0);
    check("midscan_sync", 28'(frame_sync), 28'h1);
    check("midscan_sel0", 28'(col_sel), 28'h0);
    tick();
    check("midscan_sync_once", 28'(frame_sync), 28'h0);

    // Double load: last load wins.
    a = 28'h0A5A5A5; b = 28'h3C3C3C3;
    run_to(2);  load_tick(a);
    run_to(14); load_tick(b);
    run_to(FRAME_P - 1);
    tick();
    check("double_load_b", row_bus, to_rows(b));

    // Load on the commit edge.
    c = 28'h1234567;
    run_to(FRAME_P - 1);
    load_tick(c);
    check("edge_load_row_bus", row_bus, to_rows(c));
    check("edge_load_pending", 28'(frame_pending), 28'h0);

    // Enable drop in DRIVE of column 1, then restart.
    run_to(9);
    enable = 1'b0;
    tick();
    check("drop_en", 28'(col_en_n), 28'hF);
    check("drop_sel", 28'(col_sel), 28'h0);
    enable = 1'b1;
    tick();
    check("reen_blank", 28'(col_en_n), 28'hF);
    tick(); tick();
    check("reen_drive_col0", 28'(col_en_n), 28'hE);
    check("reen_row_bus_kept", row_bus, to_rows(c));

    // Reset during DRIVE of column 2.
    run_to(15);
    reset = 1'b1;
    tick();
    check("rst_drive_en", 28'(col_en_n), 28'hF);
    check("rst_drive_row_bus", row_bus, 28'h0);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      enable     = ($urandom_range(0, 19) != 0);
      frame_load = ($urandom_range(0, 7) == 0);
      frame_in   = 28'($urandom());
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; frame_load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
